// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, display-mode encoding, bar colours and the
// per-stage control word carried down the alignment pipe.
package vga_pkg;

  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BACK   = 88;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FRONT  = 40;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BACK   = 23;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FRONT  = 1;

  localparam logic [1:0] MODE_STREAM = 2'd0;
  localparam logic [1:0] MODE_BARS   = 2'd1;
  localparam logic [1:0] MODE_GRID   = 2'd2;
  localparam logic [1:0] MODE_SOLID  = 2'd3;

  localparam logic [15:0] COL_WHITE   = 16'hFFFF;
  localparam logic [15:0] COL_YELLOW  = 16'hFFE0;
  localparam logic [15:0] COL_CYAN    = 16'h07FF;
  localparam logic [15:0] COL_GREEN   = 16'h07E0;
  localparam logic [15:0] COL_MAGENTA = 16'hF81F;
  localparam logic [15:0] COL_RED     = 16'hF800;
  localparam logic [15:0] COL_BLUE    = 16'h001F;
  localparam logic [15:0] COL_BLACK   = 16'h0000;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    logic [1:0] mode;
  } vga_ctl_t;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] col;
    case (idx)
      3'd0:    col = COL_WHITE;
      3'd1:    col = COL_YELLOW;
      3'd2:    col = COL_CYAN;
      3'd3:    col = COL_GREEN;
      3'd4:    col = COL_MAGENTA;
      3'd5:    col = COL_RED;
      3'd6:    col = COL_BLUE;
      default: col = COL_BLACK;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern source (bars / 32-pixel grid / solid); no state,
// the caller registers the result alongside its own pipeline.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int XW       = 11,
  parameter int YW       = 10
) (
  input  logic [1:0]    i_mode,
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  input  logic [15:0]   i_solid,
  output logic [15:0]   o_pix
);

  // The last bar absorbs the remainder, so the index saturates at 7.
  localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  logic [31:0] w_bar_div;
  logic [2:0]  w_bar_idx;
  logic        w_grid_on;

  always_comb begin
    w_bar_div = 32'(i_x) / 32'(BAR_W);
    w_bar_idx = (w_bar_div > 32'd7) ? 3'd7 : w_bar_div[2:0];
    w_grid_on = ((32'(i_x) & 32'h1F) == 32'd0) || ((32'(i_y) & 32'h1F) == 32'd0);
    case (i_mode)
      MODE_BARS:  o_pix = bar_color(w_bar_idx);
      MODE_GRID:  o_pix = w_grid_on ? COL_WHITE : COL_BLACK;
      MODE_SOLID: o_pix = i_solid;
      default:    o_pix = COL_BLACK;
    endcase
  end

endmodule

// File: rtl/vga_ctrl.sv
// Parametrised VGA timing + pixel source; sync/de/rgb are 3 clocks behind the counters.
// No backpressure: a stream pixel missing in its slot is filled with UFLOW_COLOR and flagged.
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int          H_SYNC      = DEF_H_SYNC,
  parameter int          H_BACK      = DEF_H_BACK,
  parameter int          H_ACTIVE    = DEF_H_ACTIVE,
  parameter int          H_FRONT     = DEF_H_FRONT,
  parameter int          V_SYNC      = DEF_V_SYNC,
  parameter int          V_BACK      = DEF_V_BACK,
  parameter int          V_ACTIVE    = DEF_V_ACTIVE,
  parameter int          V_FRONT     = DEF_V_FRONT,
  parameter int          HS_POL      = 1,
  parameter int          VS_POL      = 1,
  parameter logic [15:0] UFLOW_COLOR = 16'hF81F
) (
  input  logic        sclk,
  input  logic        s_rst,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        pix_req,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic [15:0] vga_rgb,
  output logic        frame_start,
  output logic        underflow
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BACK + V_ACTIVE);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  localparam vga_ctl_t CTL_IDLE = '{hs: ~HS_ON, vs: ~VS_ON, de: 1'b0, fs: 1'b0, mode: MODE_STREAM};

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [1:0]    r_mode_q;

  logic          w_origin;
  logic          w_act;
  logic [HW-1:0] w_x;
  logic [VW-1:0] w_y;
  vga_ctl_t      w_s0;

  vga_ctl_t      r_s1;
  vga_ctl_t      r_s2;
  logic [HW-1:0] r_x1;
  logic [HW-1:0] r_x2;
  logic [VW-1:0] r_y1;
  logic [VW-1:0] r_y2;
  logic          r_req;
  logic          r_exp2;

  logic [15:0]   w_pat;
  logic [15:0]   w_rgb;
  logic          w_starve;

  logic          r_hsync;
  logic          r_vsync;
  logic          r_de;
  logic [15:0]   r_rgb;
  logic          r_fs;
  logic          r_uflow;

  // Raster counters: h wraps every line, v advances on each h wrap.
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  assign w_origin = (r_h == '0) && (r_v == '0);

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      r_mode_q <= MODE_STREAM;
    end else if (w_origin) begin
      r_mode_q <= mode;
    end
  end

  always_comb begin
    w_act     = (r_h >= H_ACT_BEG) && (r_h < H_ACT_END) &&
                (r_v >= V_ACT_BEG) && (r_v < V_ACT_END);
    w_x       = r_h - H_ACT_BEG;
    w_y       = r_v - V_ACT_BEG;
    w_s0      = CTL_IDLE;
    w_s0.hs   = (r_h < H_SYNC_END) ? HS_ON : ~HS_ON;
    w_s0.vs   = (r_v < V_SYNC_END) ? VS_ON : ~VS_ON;
    w_s0.de   = w_act;
    w_s0.fs   = w_origin;
    w_s0.mode = r_mode_q;
  end

  // Two alignment stages; the third stage is the output register below.
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      r_s1   <= CTL_IDLE;
      r_s2   <= CTL_IDLE;
      r_x1   <= '0;
      r_x2   <= '0;
      r_y1   <= '0;
      r_y2   <= '0;
      r_req  <= 1'b0;
      r_exp2 <= 1'b0;
    end else begin
      r_s1   <= w_s0;
      r_s2   <= r_s1;
      r_x1   <= w_x;
      r_x2   <= r_x1;
      r_y1   <= w_y;
      r_y2   <= r_y1;
      r_req  <= w_act && (r_mode_q == MODE_STREAM);
      r_exp2 <= r_req;
    end
  end

  // Fed from stage 2 so solid_color is sampled on the same edge as pix_data.
  vga_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (HW),
    .YW       (VW)
  ) u_pattern (
    .i_mode  (r_s2.mode),
    .i_x     (r_x2),
    .i_y     (r_y2),
    .i_solid (solid_color),
    .o_pix   (w_pat)
  );

  always_comb begin
    w_starve = r_exp2 && !pix_valid;
    if (!r_s2.de) begin
      w_rgb = '0;
    end else if (r_exp2) begin
      w_rgb = pix_valid ? pix_data : UFLOW_COLOR;
    end else begin
      w_rgb = w_pat;
    end
  end

  // A starve landing on the frame_start cycle wins over the clear.
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      r_hsync <= ~HS_ON;
      r_vsync <= ~VS_ON;
      r_de    <= 1'b0;
      r_rgb   <= '0;
      r_fs    <= 1'b0;
      r_uflow <= 1'b0;
    end else begin
      r_hsync <= r_s2.hs;
      r_vsync <= r_s2.vs;
      r_de    <= r_s2.de;
      r_rgb   <= w_rgb;
      r_fs    <= r_s2.fs;
      r_uflow <= w_starve || (r_uflow && !r_s2.fs);
    end
  end

  assign pix_req     = r_req;
  assign vga_hsync   = r_hsync;
  assign vga_vsync   = r_vsync;
  assign vga_de      = r_de;
  assign vga_rgb     = r_rgb;
  assign frame_start = r_fs;
  assign underflow   = r_uflow;

endmodule
